// File: rtl/uart_tx_fifo_if.sv
// Write-side interface of the UART transmitter FIFO.
//   sdata      : byte to enqueue (DATA_BITS wide)
//   tx_valid   : sdata is valid this cycle
//   tx_ready   : FIFO can accept a byte (not full)
//   fifo_count : number of queued bytes, excluding the frame on the line
// master = producer of bytes, slave = the transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) ();
  logic [DATA_BITS-1:0]          sdata;
  logic                          tx_valid;
  logic                          tx_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output sdata,
    output tx_valid,
    input  tx_ready,
    input  fifo_count
  );

  modport slave (
    input  sdata,
    input  tx_valid,
    output tx_ready,
    output fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO.
// Bytes written through the interface are queued and sent as frames
// (start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits),
// each bit lasting T = 2*CLK_PER_HALF_BIT clk cycles. Frames go out
// back-to-back while the FIFO holds data.
//   clk     : clock, rising edge
//   rstn    : asynchronous active-low reset
//   wr      : write interface (sdata/tx_valid in, tx_ready/fifo_count out)
//   tx_busy : frame in flight or FIFO not empty
//   txd     : registered serial line, idle high
module uart_tx_fifo #(
  parameter int unsigned CLK_PER_HALF_BIT = 5208,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned PARITY           = 0,
  parameter int unsigned STOP_BITS        = 1,
  parameter int unsigned FIFO_DEPTH       = 16
) (
  input  logic          clk,
  input  logic          rstn,
  uart_tx_fifo_if.slave wr,
  output logic          tx_busy,
  output logic          txd
);

  localparam int unsigned BitT   = 2 * CLK_PER_HALF_BIT;
  localparam int unsigned CntW   = $clog2(BitT);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic [CountW-1:0]    count_q, count_d;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 tx_ready;
  logic                 do_wr;
  logic                 load;
  logic                 bit_end;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  assign tx_ready = (count_q != CountW'(FIFO_DEPTH));
  assign do_wr    = wr.tx_valid && tx_ready;
  assign bit_end  = (cnt_q == CntW'(BitT - 1));
  assign head     = mem_q[rd_ptr_q];
  // Even parity is the XOR of the payload; odd parity is its inverse.
  assign head_par = (^head) ^ (PARITY == 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CntW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (count_q != '0) load = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              state_d = StParity;
              txd_d   = par_q;
            end else begin
              state_d = StStop;
              idx_d   = '0;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          idx_d   = '0;
          txd_d   = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (idx_q == 3'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when data is waiting.
            if (count_q != '0) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
    if (load) begin
      state_d = StStart;
      cnt_d   = '0;
      shift_d = head;
      par_d   = head_par;
      txd_d   = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({do_wr, load})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      count_q <= count_d;
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (load)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr.sdata;
  end

  assign txd           = txd_q;
  assign tx_busy       = (state_q != StIdle) || (count_q != '0);
  assign wr.tx_ready   = tx_ready;
  assign wr.fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances cover the parity/width/stop options.
// Expected frames are queued on each accepted write and a monitor checks the
// line bit by bit (every cycle of every bit) when a start bit appears.
module tb_uart_tx_fifo;
  localparam int HalfBit = 2;
  localparam int T       = 4;
  localparam int Depth   = 4;

  typedef struct packed {
    logic [11:0] bits;
    logic [3:0]  nb;
  } frame_t;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  int unsigned cyc  = 0;
  int          tests = 0;
  int          fails = 0;
  logic [1:0]  sel  = 2'd0;
  logic        mon_en = 1'b1;
  frame_t      exp_q[$];
  int unsigned start_q[$];
  int          frames_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(Depth)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(Depth)) if1 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(Depth)) if2 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(Depth)) if3 ();
  logic txd0, txd1, txd2, txd3, busy0, busy1, busy2, busy3;

  uart_tx_fifo #(.CLK_PER_HALF_BIT(HalfBit), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .FIFO_DEPTH(Depth)) u0 (.clk(clk), .rstn(rstn), .wr(if0), .tx_busy(busy0), .txd(txd0));
  uart_tx_fifo #(.CLK_PER_HALF_BIT(HalfBit), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
    .FIFO_DEPTH(Depth)) u1 (.clk(clk), .rstn(rstn), .wr(if1), .tx_busy(busy1), .txd(txd1));
  uart_tx_fifo #(.CLK_PER_HALF_BIT(HalfBit), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
    .FIFO_DEPTH(Depth)) u2 (.clk(clk), .rstn(rstn), .wr(if2), .tx_busy(busy2), .txd(txd2));
  uart_tx_fifo #(.CLK_PER_HALF_BIT(HalfBit), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2),
    .FIFO_DEPTH(Depth)) u3 (.clk(clk), .rstn(rstn), .wr(if3), .tx_busy(busy3), .txd(txd3));

  logic       txd_m, busy_m, rdy_m;
  logic [2:0] cnt_m;

  always_comb begin
    txd_m  = txd0;
    busy_m = busy0;
    rdy_m  = if0.tx_ready;
    cnt_m  = if0.fifo_count;
    case (sel)
      2'd1: begin txd_m = txd1; busy_m = busy1; rdy_m = if1.tx_ready; cnt_m = if1.fifo_count; end
      2'd2: begin txd_m = txd2; busy_m = busy2; rdy_m = if2.tx_ready; cnt_m = if2.fifo_count; end
      2'd3: begin txd_m = txd3; busy_m = busy3; rdy_m = if3.tx_ready; cnt_m = if3.fifo_count; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame for instance s: start, payload LSB first, parity, stops.
  function automatic frame_t mk(input logic [1:0] s, input logic [7:0] d);
    frame_t f;
    int     n;
    int     db;
    int     par;
    int     sb;
    logic   p;
    db  = (s == 2'd3) ? 7 : 8;
    par = (s == 2'd1) ? 2 : (s == 2'd2) ? 1 : 0;
    sb  = (s == 2'd3) ? 2 : 1;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < db; i++) begin
      f.bits[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (par != 0) begin
      f.bits[n] = (par == 1) ? ~p : p;
      n++;
    end
    n = n + sb;
    f.nb = 4'(n);
    return f;
  endfunction

  task automatic wr(input logic [1:0] s, input logic [7:0] d, input bit acc);
    case (s)
      2'd0: begin if0.sdata = d; if0.tx_valid = 1'b1; end
      2'd1: begin if1.sdata = d; if1.tx_valid = 1'b1; end
      2'd2: begin if2.sdata = d; if2.tx_valid = 1'b1; end
      default: begin if3.sdata = d[6:0]; if3.tx_valid = 1'b1; end
    endcase
    if (acc) exp_q.push_back(mk(s, d));
    @(negedge clk);
    if0.tx_valid = 1'b0;
    if1.tx_valid = 1'b0;
    if2.tx_valid = 1'b0;
    if3.tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int n);
    n = 0;
    while ((busy_m !== 1'b0 || exp_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < limit), 32'd1);
  endtask

  // Line monitor: checks every cycle of every bit against the queued frame.
  always begin : mon
    frame_t f;
    logic   bad;
    @(negedge clk);
    if (mon_en && rstn && txd_m === 1'b0) begin
      start_q.push_back(cyc);
      frames_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'd1, 32'd0);
      end else begin
        f = exp_q.pop_front();
        for (int b = 0; b < int'(f.nb) && mon_en; b++) begin
          bad = 1'b0;
          for (int c = 0; c < T && mon_en; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (txd_m !== f.bits[b]) bad = 1'b1;
          end
          if (mon_en) chk($sformatf("frame%0d_bit%0d", frames_seen, b), 32'(bad), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int unsigned w;
    int unsigned s0, s1, s2;
    int          fs;
    if0.tx_valid = 1'b0; if0.sdata = '0;
    if1.tx_valid = 1'b0; if1.sdata = '0;
    if2.tx_valid = 1'b0; if2.sdata = '0;
    if3.tx_valid = 1'b0; if3.sdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_count", 32'(if0.fifo_count), 32'd0);
    chk("rst_ready", 32'(if0.tx_ready), 32'd1);
    chk("rst_txd3", 32'(txd3), 32'd1);
    rstn = 1'b1;

    // Write on first edge after reset, 0xA5 frame timing
    sel = 2'd0;
    wr(2'd0, 8'hA5, 1'b1);
    w = cyc;
    chk("a5_count_after_wr", 32'(cnt_m), 32'd1);
    chk("a5_busy_after_wr", 32'(busy_m), 32'd1);
    chk("a5_txd_before_start", 32'(txd_m), 32'd1);
    @(negedge clk);
    chk("a5_start_low", 32'(txd_m), 32'd0);
    chk("a5_count_after_pop", 32'(cnt_m), 32'd0);
    repeat (39) @(negedge clk);
    chk("a5_busy_last_stop", 32'(busy_m), 32'd1);
    chk("a5_txd_last_stop", 32'(txd_m), 32'd1);
    @(negedge clk);
    chk("a5_busy_dropped", 32'(busy_m), 32'd0);
    chk("a5_start_delay", start_q.pop_front() - w, 32'd1);
    chk("a5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Three consecutive writes -> back-to-back frames
    start_q.delete();
    wr(2'd0, 8'h11, 1'b1);
    wr(2'd0, 8'h22, 1'b1);
    wr(2'd0, 8'h33, 1'b1);
    chk("b2b_peak_count", 32'(cnt_m), 32'd2);
    wait_done("b2b_done", 300, n);
    chk("b2b_frames", 32'(start_q.size()), 32'd3);
    s0 = start_q.pop_front();
    s1 = start_q.pop_front();
    s2 = start_q.pop_front();
    chk("b2b_gap01", s1 - s0, 32'd40);
    chk("b2b_gap12", s2 - s1, 32'd40);

    // Overflow: 6 writes during a frame, last two dropped
    fs = frames_seen;
    wr(2'd0, 8'h01, 1'b1);
    repeat (3) @(negedge clk);
    chk("ovf_count_zero", 32'(cnt_m), 32'd0);
    wr(2'd0, 8'hC1, 1'b1);
    wr(2'd0, 8'hC2, 1'b1);
    wr(2'd0, 8'hC3, 1'b1);
    wr(2'd0, 8'hC4, 1'b1);
    chk("ovf_count_full", 32'(cnt_m), 32'd4);
    chk("ovf_ready_low", 32'(rdy_m), 32'd0);
    wr(2'd0, 8'hC5, 1'b0);
    wr(2'd0, 8'hC6, 1'b0);
    chk("ovf_count_hold", 32'(cnt_m), 32'd4);
    wait_done("ovf_done", 600, n);
    chk("ovf_frames", 32'(frames_seen - fs), 32'd5);
    chk("ovf_ready_back", 32'(rdy_m), 32'd1);

    // Even parity, 0x07
    sel = 2'd1;
    wr(2'd1, 8'h07, 1'b1);
    wait_done("even_done", 200, n);
    chk("even_frame_len", 32'(n), 32'd45);

    // Odd parity, 0x07
    sel = 2'd2;
    wr(2'd2, 8'h07, 1'b1);
    wait_done("odd_done", 200, n);
    chk("odd_frame_len", 32'(n), 32'd45);

    // 7 data bits, 2 stop bits; bit 7 of the input ignored
    sel = 2'd3;
    wr(2'd3, 8'hFF, 1'b1);
    wait_done("d7s2_done", 200, n);
    chk("d7s2_frame_len", 32'(n), 32'd41);

    // Reset mid-frame with two bytes queued
    sel = 2'd0;
    wr(2'd0, 8'h00, 1'b1);
    wr(2'd0, 8'h3C, 1'b1);
    wr(2'd0, 8'h96, 1'b1);
    repeat (8) @(negedge clk);
    chk("mid_txd_low", 32'(txd_m), 32'd0);
    chk("mid_count", 32'(cnt_m), 32'd2);
    mon_en = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    chk("arst_txd", 32'(txd_m), 32'd1);
    chk("arst_count", 32'(cnt_m), 32'd0);
    chk("arst_ready", 32'(rdy_m), 32'd1);
    chk("arst_busy", 32'(busy_m), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;
    fs = frames_seen;
    repeat (60) @(negedge clk);
    chk("post_rst_no_frame", 32'(frames_seen - fs), 32'd0);
    chk("post_rst_txd", 32'(txd_m), 32'd1);
    chk("post_rst_busy", 32'(busy_m), 32'd0);

    // A new write after reset goes out normally
    wr(2'd0, 8'h5A, 1'b1);
    wait_done("post_rst_done", 200, n);
    chk("post_rst_frame", 32'(frames_seen - fs), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL provide parameter CLK_PER_HALF_BIT, default 5208: half a bit period in clk cycles; bit period T = 2*CLK_PER_HALF_BIT cycles.
REQ-002 The block SHALL provide parameter DATA_BITS, default 8: payload width, legal range 5..8.
REQ-003 The block SHALL provide parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-004 The block SHALL provide parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 The block SHALL provide parameter FIFO_DEPTH, default 16: entry count, power of two, minimum 2.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rstn  input  1  reset; asynchronous assert, active-low, release synchronous to clk.
REQ-008 sdata  input  DATA_BITS  byte to enqueue.
REQ-009 tx_valid  input  1  sdata valid this cycle.
REQ-010 tx_ready  output  1  FIFO can accept; equals (count != FIFO_DEPTH).
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued, excluding the frame in flight.
REQ-012 tx_busy  output  1  high while a frame is in flight or fifo_count != 0.
REQ-013 txd  output  1  serial line, registered, idle high.

Function
REQ-014 A write SHALL occur on a rising edge where tx_valid && tx_ready; sdata is stored at the tail; no write when tx_ready is low (data dropped, no state change).
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 In IDLE with fifo_count != 0, the next edge SHALL pop the head into the shift register, enter START and drive txd low; a byte written into an empty FIFO while IDLE therefore starts one cycle after its write edge.
REQ-017 Each of START, every DATA bit, PARITY and every stop bit SHALL hold txd for exactly T cycles, timed by a bit counter cleared on frame start and at each bit boundary.
REQ-018 DATA SHALL send DATA_BITS bits LSB first, then go to PARITY if PARITY != 0, else STOP.
REQ-019 PARITY bit SHALL be XOR of the payload bits (even) or its inverse (odd), computed from the popped value.
REQ-020 STOP SHALL drive txd high for STOP_BITS*T cycles.
REQ-021 At the end of STOP, if fifo_count != 0, the FSM SHALL pop and enter START on the same edge (no idle gap between frames); otherwise return to IDLE with txd high.
REQ-022 Simultaneous write and pop on one edge SHALL leave fifo_count unchanged and both succeed; with FIFO full, tx_ready is low so only the pop occurs.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL derive from fifo_count, not pointer equality alone.
REQ-024 tx_ready and fifo_count SHALL reflect the state after the previous edge (registered count, combinational compare).

Reset
REQ-025 While rstn is low: txd = 1, tx_busy = 0, fifo_count = 0, tx_ready = 1, FSM = IDLE, bit counter = 0, pointers = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (txd high without waiting for clk) and discard all queued entries.
REQ-027 The first write SHALL be accepted on the first rising edge after rstn deasserts.

Verification (CLK_PER_HALF_BIT=2, T=4, DATA_BITS=8, FIFO_DEPTH=4 unless stated)
REQ-028 PARITY=0, STOP_BITS=1, write 0xA5 -> from the next cycle txd = 0, then 1,0,1,0,0,1,0,1, then 1, each 4 cycles (40 cycles total); tx_busy drops at frame end.
REQ-029 PARITY=2, write 0x07 -> parity bit 1 after data; PARITY=1, write 0x07 -> parity bit 0; frame 44 cycles.
REQ-030 Write 0x11,0x22,0x33 on consecutive cycles -> three frames back-to-back with no idle-high cycle between stop and next start; fifo_count peaks at 2.
REQ-031 While the first frame is in flight, write 6 bytes continuously -> tx_ready falls when fifo_count = 4; the 5th and 6th bytes are dropped; exactly 5 frames are sent.
REQ-032 DATA_BITS=7, STOP_BITS=2, write 0x7F -> start, seven 1s, stop high for 8 cycles; bit 7 of any input is ignored.
REQ-033 Assert rstn low at cycle 10 of a frame with 2 bytes queued -> txd = 1 and fifo_count = 0 within the same cycle; after release no frame is sent until a new write.
